// File: rtl/cpu_seq_ctrl_if.sv
//------------------------------------------------------------------------------
// Module : cpu_seq_ctrl_if
// Brief  : Instruction-memory, ALU, register-file and status bundle between
//          the sequencer (master) and the CPU datapath (slave).
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface cpu_seq_ctrl_if;
    logic        start;
    logic [7:0]  imem_addr;
    logic [15:0] imem_rdata;
    logic        alu_zero;
    logic        alu_carry;
    logic [2:0]  alu_op;
    logic [2:0]  rf_raddr_a;
    logic [2:0]  rf_raddr_b;
    logic [2:0]  rf_waddr;
    logic        rf_we;
    logic        rf_wsel;
    logic [7:0]  imm;
    logic        flag_z;
    logic        flag_c;
    logic        busy;
    logic        halted;
    logic        illegal;

    modport master (
        input  start, imem_rdata, alu_zero, alu_carry,
        output imem_addr, alu_op, rf_raddr_a, rf_raddr_b, rf_waddr, rf_we,
               rf_wsel, imm, flag_z, flag_c, busy, halted, illegal
    );

    modport slave (
        output start, imem_rdata, alu_zero, alu_carry,
        input  imem_addr, alu_op, rf_raddr_a, rf_raddr_b, rf_waddr, rf_we,
               rf_wsel, imm, flag_z, flag_c, busy, halted, illegal
    );
endinterface

`default_nettype wire

// File: rtl/cpu_seq_ctrl.sv
//------------------------------------------------------------------------------
// Module : cpu_seq_ctrl
// Brief  : Four-state fetch/decode/execute/writeback sequencer for the 8-bit
//          CPU, holding pc, ir and the Z/C flags and resolving branches.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module cpu_seq_ctrl (
    input  wire logic      clk,
    input  wire logic      rst_n,
    cpu_seq_ctrl_if.master bus
);

    localparam logic [3:0] c_OP_LDI  = 4'b1000;
    localparam logic [3:0] c_OP_JMP  = 4'b1001;
    localparam logic [3:0] c_OP_JZ   = 4'b1010;
    localparam logic [3:0] c_OP_JC   = 4'b1011;
    localparam logic [3:0] c_OP_ILL0 = 4'b1101;
    localparam logic [3:0] c_OP_ILL1 = 4'b1110;
    localparam logic [3:0] c_OP_HALT = 4'b1111;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic        flag_z_q, flag_z_d;
    logic        flag_c_q, flag_c_d;
    logic        rf_we_q, rf_we_d;
    logic        illegal_q, illegal_d;
    logic        busy_q, busy_d;
    logic        halted_q, halted_d;
    // Low for the first clock after reset release so a start pulse
    // overlapping the release cannot launch execution.
    logic        armed_q, armed_d;

    logic [3:0]  w_op;
    logic        w_is_alu;
    logic        w_is_ldi;
    logic        w_is_halt;
    logic        w_is_illegal;
    logic        w_taken;

    assign w_op         = ir_q[15:12];
    assign w_is_alu     = ~w_op[3];
    assign w_is_ldi     = (w_op == c_OP_LDI);
    assign w_is_halt    = (w_op == c_OP_HALT);
    assign w_is_illegal = (w_op == c_OP_ILL0) || (w_op == c_OP_ILL1);
    assign w_taken      = (w_op == c_OP_JMP)
                       || ((w_op == c_OP_JZ) && flag_z_q)
                       || ((w_op == c_OP_JC) && flag_c_q);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        flag_z_d  = flag_z_q;
        flag_c_d  = flag_c_q;
        rf_we_d   = 1'b0;
        illegal_d = 1'b0;
        armed_d   = 1'b1;

        case (state_q)
            S_IDLE, S_HALT: begin
                if (bus.start && armed_q) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                state_d = S_DECODE;
            end
            S_DECODE: begin
                ir_d    = bus.imem_rdata;
                state_d = S_EXECUTE;
            end
            S_EXECUTE: begin
                // Only add/sub produce a meaningful carry; logic ops clear it.
                if (w_is_alu) begin
                    flag_z_d = bus.alu_zero;
                    flag_c_d = (w_op[2:1] == 2'b00) ? bus.alu_carry : 1'b0;
                end
                rf_we_d   = w_is_alu || w_is_ldi;
                illegal_d = w_is_illegal;
                state_d   = S_WRITEBACK;
            end
            S_WRITEBACK: begin
                if (w_is_halt) begin
                    state_d = S_HALT;
                end else begin
                    pc_d    = w_taken ? ir_q[7:0] : pc_q + 8'd1;
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d   = (state_d == S_FETCH) || (state_d == S_DECODE)
                || (state_d == S_EXECUTE) || (state_d == S_WRITEBACK);
        halted_d = (state_d == S_HALT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pc_q      <= 8'h00;
            ir_q      <= 16'h0000;
            flag_z_q  <= 1'b0;
            flag_c_q  <= 1'b0;
            rf_we_q   <= 1'b0;
            illegal_q <= 1'b0;
            busy_q    <= 1'b0;
            halted_q  <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            flag_z_q  <= flag_z_d;
            flag_c_q  <= flag_c_d;
            rf_we_q   <= rf_we_d;
            illegal_q <= illegal_d;
            busy_q    <= busy_d;
            halted_q  <= halted_d;
            armed_q   <= armed_d;
        end
    end

    // Datapath controls come straight from ir so they stay stable through
    // EXECUTE and WRITEBACK up to the register-file write edge.
    assign bus.imem_addr  = pc_q;
    assign bus.alu_op     = ir_q[14:12];
    assign bus.rf_raddr_a = ir_q[8:6];
    assign bus.rf_raddr_b = ir_q[5:3];
    assign bus.rf_waddr   = ir_q[11:9];
    assign bus.rf_wsel    = w_is_ldi;
    assign bus.imm        = ir_q[7:0];
    assign bus.rf_we      = rf_we_q;
    assign bus.illegal    = illegal_q;
    assign bus.flag_z     = flag_z_q;
    assign bus.flag_c     = flag_c_q;
    assign bus.busy       = busy_q;
    assign bus.halted     = halted_q;

endmodule

`default_nettype wire

// File: tb/tb_cpu_seq_ctrl.sv
//------------------------------------------------------------------------------
// Module : tb_cpu_seq_ctrl
// Brief  : Self-checking bench for cpu_seq_ctrl with memory, register file,
//          ALU and an instruction-level reference model.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_cpu_seq_ctrl;

    logic clk;
    logic rst_n;

    cpu_seq_ctrl_if bus ();

    cpu_seq_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [15:0] mem [256];
    logic [7:0]  rf  [8];
    logic [7:0]  alu_a, alu_b, alu_y;
    logic        alu_co;
    int          n_cmp;
    int          n_err;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) bus.imem_rdata <= mem[bus.imem_addr];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) rf[i] <= 8'h00;
        end else if (bus.rf_we) begin
            rf[bus.rf_waddr] <= bus.rf_wsel ? bus.imm : alu_y;
        end
    end

    // Carry for the logic ops is deliberately non-zero so flag clearing is visible.
    always_comb begin
        alu_a  = rf[bus.rf_raddr_a];
        alu_b  = rf[bus.rf_raddr_b];
        alu_y  = 8'h00;
        alu_co = 1'b0;
        case (bus.alu_op)
            3'd0:    {alu_co, alu_y} = {1'b0, alu_a} + {1'b0, alu_b};
            3'd1:    {alu_co, alu_y} = {1'b0, alu_a} - {1'b0, alu_b};
            3'd2:    begin alu_y = alu_a & alu_b; alu_co = ^alu_y; end
            3'd3:    begin alu_y = alu_a | alu_b; alu_co = ^alu_y; end
            3'd4:    begin alu_y = alu_a ^ alu_b; alu_co = 1'b1;   end
            3'd5:    begin alu_y = alu_a << 1;    alu_co = alu_a[7]; end
            3'd6:    begin alu_y = alu_a >> 1;    alu_co = alu_a[0]; end
            default: begin alu_y = ~alu_a;        alu_co = 1'b1;   end
        endcase
    end
    assign bus.alu_zero  = (alu_y == 8'h00);
    assign bus.alu_carry = alu_co;

    // Instruction-level reference model.
    logic [7:0] m_rf [8];
    logic       m_z, m_c;
    logic [7:0] m_pc;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_rf[i] = 8'h00;
        m_z  = 1'b0;
        m_c  = 1'b0;
        m_pc = 8'h00;
    endtask

    task automatic model_step(input logic [15:0] w, output logic we, output logic wsel,
                              output logic ill, output logic hlt);
        int op, a, b, r;
        op = int'(w[15:12]);
        a  = int'(m_rf[w[8:6]]);
        b  = int'(m_rf[w[5:3]]);
        we = 1'b0; wsel = 1'b0; ill = 1'b0; hlt = 1'b0;
        if (op < 8) begin
            case (op)
                0:       r = a + b;
                1:       r = a - b;
                2:       r = a & b;
                3:       r = a | b;
                4:       r = a ^ b;
                5:       r = (a * 2) % 256;
                6:       r = a / 2;
                default: r = 255 - a;
            endcase
            m_c  = (op == 0) ? (r > 255) : ((op == 1) ? (r < 0) : 1'b0);
            r    = (r + 256) % 256;
            m_z  = (r == 0);
            m_rf[w[11:9]] = r[7:0];
            we   = 1'b1;
            m_pc = m_pc + 8'd1;
        end else begin
            case (op)
                8:       begin m_rf[w[11:9]] = w[7:0]; we = 1'b1; wsel = 1'b1; m_pc = m_pc + 8'd1; end
                9:       m_pc = w[7:0];
                10:      m_pc = m_z ? w[7:0] : m_pc + 8'd1;
                11:      m_pc = m_c ? w[7:0] : m_pc + 8'd1;
                13, 14:  begin ill = 1'b1; m_pc = m_pc + 8'd1; end
                15:      hlt = 1'b1;
                default: m_pc = m_pc + 8'd1;
            endcase
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at the FETCH sample point; returns at the next FETCH/HALT sample.
    task automatic run_instr(input bit noisy, output int we_cnt, output int ill_cnt,
                             output logic we_wb, output logic wsel_wb, output logic ill_wb);
        we_cnt = 0; ill_cnt = 0; we_wb = 1'b0; wsel_wb = 1'b0; ill_wb = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            if (bus.rf_we)   we_cnt++;
            if (bus.illegal) ill_cnt++;
            if (k == 3) begin
                we_wb   = bus.rf_we;
                wsel_wb = bus.rf_wsel;
                ill_wb  = bus.illegal;
            end
            bus.start = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    typedef struct packed {
        logic [7:0]  addr;
        logic [15:0] instr;
        logic [7:0]  npc;
        logic        z, c, we, wsel, ill;
        logic [2:0]  ridx;
        logic [7:0]  rval;
    } vec_t;

    vec_t vecs [18];

    function automatic logic [63:0] pack_rf();
        logic [63:0] v;
        for (int i = 0; i < 8; i++) v[i*8 +: 8] = rf[i];
        return v;
    endfunction

    function automatic logic [63:0] pack_mrf();
        logic [63:0] v;
        for (int i = 0; i < 8; i++) v[i*8 +: 8] = m_rf[i];
        return v;
    endfunction

    initial begin
        int         we_cnt, ill_cnt, seen;
        logic       we_wb, wsel_wb, ill_wb;
        logic       e_we, e_wsel, e_ill, e_hlt;
        logic [15:0] w;

        n_cmp = 0;
        n_err = 0;
        bus.start = 1'b0;
        rst_n = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 16'hC000;

        //             addr   instr     npc    z     c     we    wsel  ill   ridx  rval
        vecs[0]  = '{8'h00, 16'h82F0, 8'h01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd1, 8'hF0};
        vecs[1]  = '{8'h01, 16'h8420, 8'h02, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd2, 8'h20};
        vecs[2]  = '{8'h02, 16'h0650, 8'h03, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd3, 8'h10};
        vecs[3]  = '{8'h03, 16'h1890, 8'h04, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd4, 8'h00};
        vecs[4]  = '{8'h04, 16'hA040, 8'h40, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 8'h00};
        vecs[5]  = '{8'h40, 16'h1A50, 8'h41, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd5, 8'hD0};
        vecs[6]  = '{8'h41, 16'hA080, 8'h42, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd5, 8'hD0};
        vecs[7]  = '{8'h42, 16'h0C48, 8'h43, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd6, 8'hE0};
        vecs[8]  = '{8'h43, 16'h2E50, 8'h44, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd7, 8'h20};
        vecs[9]  = '{8'h44, 16'hB010, 8'h45, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd7, 8'h20};
        vecs[10] = '{8'h45, 16'h7040, 8'h46, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'h0F};
        vecs[11] = '{8'h46, 16'h1688, 8'h47, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd3, 8'h30};
        vecs[12] = '{8'h47, 16'hB090, 8'h90, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 8'h30};
        vecs[13] = '{8'h90, 16'hD000, 8'h91, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd3, 8'h30};
        vecs[14] = '{8'h91, 16'hC000, 8'h92, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 8'h30};
        vecs[15] = '{8'h92, 16'h90FE, 8'hFE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 8'h30};
        vecs[16] = '{8'hFE, 16'h8201, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd1, 8'h01};
        vecs[17] = '{8'hFF, 16'hC000, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 8'h01};
        for (int i = 0; i < 18; i++) mem[vecs[i].addr] = vecs[i].instr;

        // Reset values while rst_n is held low.
        repeat (2) @(posedge clk); #1;
        chk("rst_busy",   bus.busy,       0);
        chk("rst_halted", bus.halted,     0);
        chk("rst_we",     bus.rf_we,      0);
        chk("rst_ill",    bus.illegal,    0);
        chk("rst_addr",   bus.imem_addr,  0);
        chk("rst_aluop",  bus.alu_op,     0);
        chk("rst_rfaddr", {bus.rf_raddr_a, bus.rf_raddr_b, bus.rf_waddr}, 0);
        chk("rst_wsel",   bus.rf_wsel,    0);
        chk("rst_imm",    bus.imm,        0);
        chk("rst_flags",  {bus.flag_z, bus.flag_c}, 0);

        // Start overlapping reset release is ignored; then ten idle cycles.
        @(negedge clk);
        rst_n = 1'b1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.rf_we || bus.busy || bus.imem_addr != 8'h00) seen++;
            @(posedge clk); #1;
        end
        chk("idle_activity", seen, 0);
        chk("idle_busy", bus.busy, 0);
        chk("idle_addr", bus.imem_addr, 0);

        // Directed program table.
        pulse_start();
        for (int i = 0; i < 18; i++) begin
            chk($sformatf("v%0d_fetch", i), bus.imem_addr, vecs[i].addr);
            chk($sformatf("v%0d_busy", i), bus.busy, 1);
            run_instr(1'b0, we_cnt, ill_cnt, we_wb, wsel_wb, ill_wb);
            chk($sformatf("v%0d_we_cnt", i), we_cnt, vecs[i].we);
            chk($sformatf("v%0d_we_wb", i), we_wb, vecs[i].we);
            if (vecs[i].we) chk($sformatf("v%0d_wsel", i), wsel_wb, vecs[i].wsel);
            chk($sformatf("v%0d_ill_cnt", i), ill_cnt, vecs[i].ill);
            chk($sformatf("v%0d_ill_wb", i), ill_wb, vecs[i].ill);
            chk($sformatf("v%0d_flags", i), {bus.flag_z, bus.flag_c}, {vecs[i].z, vecs[i].c});
            chk($sformatf("v%0d_npc", i), bus.imem_addr, vecs[i].npc);
            chk($sformatf("v%0d_reg", i), rf[vecs[i].ridx], vecs[i].rval);
        end

        // HALT at 0x05, then resume from the same pc.
        for (int i = 0; i < 5; i++) mem[i] = 16'hC000;
        mem[5] = 16'hF000;
        mem[6] = 16'h8477;
        do_reset();
        pulse_start();
        for (int i = 0; i < 5; i++) run_instr(1'b0, we_cnt, ill_cnt, we_wb, wsel_wb, ill_wb);
        chk("halt_fetch", bus.imem_addr, 8'h05);
        run_instr(1'b0, we_cnt, ill_cnt, we_wb, wsel_wb, ill_wb);
        chk("halt_halted", bus.halted, 1);
        chk("halt_busy", bus.busy, 0);
        chk("halt_we", we_cnt, 0);
        repeat (5) @(posedge clk);
        #1;
        chk("halt_hold", bus.halted, 1);
        chk("halt_pc", bus.imem_addr, 8'h05);
        pulse_start();
        chk("resume_busy", bus.busy, 1);
        chk("resume_halted", bus.halted, 0);
        chk("resume_addr", bus.imem_addr, 8'h05);
        run_instr(1'b0, we_cnt, ill_cnt, we_wb, wsel_wb, ill_wb);
        chk("rehalt", bus.halted, 1);

        // Reset during the EXECUTE of an ADD.
        mem[0] = 16'h82F0;
        mem[1] = 16'h8420;
        mem[2] = 16'h1A90;
        mem[3] = 16'h0650;
        do_reset();
        pulse_start();
        for (int i = 0; i < 3; i++) run_instr(1'b0, we_cnt, ill_cnt, we_wb, wsel_wb, ill_wb);
        chk("pre_abort_z", bus.flag_z, 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", bus.busy, 0);
        chk("abort_flags", {bus.flag_z, bus.flag_c}, 0);
        chk("abort_pc", bus.imem_addr, 0);
        chk("abort_we", bus.rf_we, 0);
        seen = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (bus.rf_we) seen++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (bus.rf_we || bus.busy || bus.flag_z || bus.flag_c) seen++;
        end
        chk("abort_quiet", seen, 0);
        chk("abort_r3", rf[3], 8'h00);
        pulse_start();
        chk("abort_refetch", bus.imem_addr, 8'h00);

        // Random programs against the reference model.
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        do_reset();
        pulse_start();
        for (int n = 0; n < 300; n++) begin
            w = mem[m_pc];
            model_step(w, e_we, e_wsel, e_ill, e_hlt);
            run_instr(1'b1, we_cnt, ill_cnt, we_wb, wsel_wb, ill_wb);
            chk("rnd_we_cnt", we_cnt, e_we);
            chk("rnd_we_wb", we_wb, e_we);
            if (e_we) chk("rnd_wsel", wsel_wb, e_wsel);
            chk("rnd_ill", {ill_cnt[7:0], ill_wb}, {7'd0, e_ill, e_ill});
            chk("rnd_flags", {bus.flag_z, bus.flag_c}, {m_z, m_c});
            chk("rnd_pc", bus.imem_addr, m_pc);
            chk("rnd_halted", bus.halted, e_hlt);
            chk("rnd_regs", pack_rf(), pack_mrf());
            if (e_hlt) pulse_start();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cpu_seq_ctrl.md
# cpu_seq_ctrl

Multi-cycle control unit for the 8-bit CPU. Fetches 16-bit instructions from a synchronous instruction memory, decodes them, and sequences the register file and the 8-bit ALU (3-bit opcode, zero and carry outputs) through a fixed four-state execute loop. It also keeps the program counter and the Z/C flag register, and resolves branches.

## Interface
- No parameters: widths are fixed (8-bit data/PC, 16-bit instruction, 8 registers).
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle pulse; leaves IDLE/HALT and begins fetching at current pc
- imem_addr  out  8  instruction address (= pc)
- imem_rdata  in  16  instruction word, valid one cycle after imem_addr is presented
- alu_zero  in  1  ALU zero output
- alu_carry  in  1  ALU carry output
- alu_op  out  3  ALU opcode
- rf_raddr_a / rf_raddr_b  out  3 each  register-file read addresses (combinational read)
- rf_waddr  out  3  write address
- rf_we  out  1  write enable
- rf_wsel  out  1  write-data select: 0 = ALU result, 1 = imm
- imm  out  8  ir[7:0]
- flag_z / flag_c  out  1 each  flag register
- busy  out  1  high in FETCH/DECODE/EXECUTE/WRITEBACK
- halted  out  1  high in HALT
- illegal  out  1  one-cycle pulse in WRITEBACK for undefined opcode

## Operation
- Instruction format: op = ir[15:12], rd = ir[11:9], ra = ir[8:6], rb = ir[5:3], imm8 = ir[7:0].
- op 0xxx: ALU, alu_op = op[2:0], rd <= ALU(ra, rb). NOT (111) uses ra only; rb is don't-care.
- 1000 LDI: rd <= imm8. 1001 JMP imm8. 1010 JZ (taken if flag_z). 1011 JC (taken if flag_c). 1100 NOP. 1111 HALT. 1101/1110: illegal, executed as NOP with an illegal pulse.
- States: IDLE -> (start) FETCH -> DECODE -> EXECUTE -> WRITEBACK -> FETCH. From WRITEBACK, a HALT instruction goes to HALT instead. HALT -> (start) FETCH.
- FETCH: imem_addr = pc.
- DECODE: ir <= imem_rdata.
- EXECUTE: rf_raddr_a = ra, rf_raddr_b = rb, alu_op driven. At the end of this state, ALU ops update flags:
  - flag_z <= alu_zero for every ALU op.
  - flag_c <= alu_carry for op 000/001 (sub carry = bit 8 of the 9-bit difference, i.e. borrow).
  - flag_c <= 0 for op 010–111.
  - Non-ALU instructions leave flags unchanged.
- WRITEBACK:
  - rf_we = 1 for ALU/LDI, with rf_waddr = rd and rf_wsel = 1 for LDI only.
  - pc <= imm8 if the jump is taken, else pc + 1 (mod 256; 0xFF wraps to 0x00).
  - HALT does not advance pc.
- rf_raddr_a/b and alu_op are held from ir through EXECUTE and WRITEBACK, so the ALU result is stable at the write edge. They are driven from ir in all states.
- JZ/JC test the flags as they stand before this instruction; a branch never updates flags.
- start while busy is ignored.

## Timing
- Exactly 4 cycles per instruction; no stalls.
- The first fetch cycle follows the start edge. rf_we is high for exactly one cycle per writing instruction.
- Reset (asynchronous, any state): state = IDLE, pc = 0x00, ir = 0x0000, flag_z = 0, flag_c = 0.
  - Outputs during reset: rf_we = 0, busy = 0, halted = 0, illegal = 0, imem_addr = 0x00, alu_op = 000, rf addresses 0, rf_wsel = 0, imm = 0x00.
- Reset asserted mid-instruction aborts it: no write and no flag/pc update after the reset edge.
- A start pulse coincident with reset release is ignored.
- Branch target takes effect at the next FETCH, with no delay slot.
- Flags written at the end of EXECUTE are visible to a branch starting 1 cycle later (next instruction).

## Test plan
- Reset then idle: after rst_n rises, no start for 10 cycles -> busy = 0, pc = 0x00, rf_we never asserted, imem_addr = 0x00.
- LDI r1,0xF0; LDI r2,0x20; ADD r3,r1,r2 -> r3 = 0x10, flag_c = 1, flag_z = 0. rf_we pulses at cycles 4, 8 and 12 after start, with rf_wsel = 1, 1, 0.
- SUB r4,r2,r2, then JZ 0x40 -> flag_z = 1, flag_c = 0; next imem_addr = 0x40. Repeat with nonzero result -> pc = next sequential.
- AND after a carry-setting ADD -> flag_c cleared to 0; JC is not taken. Place JMP 0x00 at 0xFF -> pc wraps correctly, and sequential execution at 0xFF proceeds to 0x00.
- Opcode 0xD000 -> illegal pulses once, no rf_we, pc += 1. HALT at 0x05 -> halted = 1, pc stays 0x05; a start pulse resumes at 0x05.
- rst_n dropped during the EXECUTE of an ADD -> no rf_we, flags 0, pc 0x00, state IDLE; the next start refetches from 0x00.
